// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
// State encodings are fixed so o_state reads back stably.
package pipeline_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_RUN   = 3'b001,
        S_STEP  = 3'b010,
        S_DRAIN = 3'b011,
        S_DONE  = 3'b100
    } state_e;

    localparam logic [5:0] HALT_OPCODE = 6'h3F;
    localparam int unsigned DRAIN_DEFAULT = 4;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Debug/hazard inputs and pipeline control outputs of the sequencer.
// master = debug unit + datapath side, slave = sequencer.
interface pipeline_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             i_dbg_run;
    logic             i_dbg_step;
    logic             i_dbg_pause;
    logic             i_idex_memRead;
    logic [4:0]       i_idex_rt;
    logic [4:0]       i_ifid_rs;
    logic [4:0]       i_ifid_rt;
    logic             i_branch_taken;
    logic             i_halt_instr;
    logic             o_halt;
    logic             o_pc_write;
    logic             o_ifid_write;
    logic             o_idex_stall;
    logic             o_ifid_flush;
    logic             o_done;
    logic [2:0]       o_state;
    logic [CNT_W-1:0] o_cycle_cnt;

    modport master (
        output i_dbg_run, i_dbg_step, i_dbg_pause,
        output i_idex_memRead, i_idex_rt,
        output i_ifid_rs, i_ifid_rt,
        output i_branch_taken, i_halt_instr,
        input  o_halt, o_pc_write, o_ifid_write,
        input  o_idex_stall, o_ifid_flush,
        input  o_done, o_state, o_cycle_cnt
    );

    modport slave (
        input  i_dbg_run, i_dbg_step, i_dbg_pause,
        input  i_idex_memRead, i_idex_rt,
        input  i_ifid_rs, i_ifid_rt,
        input  i_branch_taken, i_halt_instr,
        output o_halt, o_pc_write, o_ifid_write,
        output o_idex_stall, o_ifid_flush,
        output o_done, o_state, o_cycle_cnt
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_unit.sv
// Load-use hazard detect: load in EX writes a register read in ID.
// Register 0 is never a real dependency.
module hazard_unit (
    input  logic       memread_i,
    input  logic [4:0] ex_rt_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    output logic       hazard_o
);

    assign hazard_o = memread_i
                    & (ex_rt_i != 5'd0)
                    & ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: run/step/pause gating, load-use stall,
// branch squash and post-HALT drain.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = DRAIN_DEFAULT,
    parameter int unsigned CNT_W        = 32
) (
    input  logic            clk,
    input  logic            i_rst,
    pipeline_ctrl_if.slave  bus
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    state_e           state_q, state_d;
    logic [3:0]       drain_q, drain_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q;

    logic hazard;
    logic halt_taken;
    logic halt_w;

    hazard_unit u_hazard (
        .memread_i (bus.i_idex_memRead),
        .ex_rt_i   (bus.i_idex_rt),
        .id_rs_i   (bus.i_ifid_rs),
        .id_rt_i   (bus.i_ifid_rt),
        .hazard_o  (hazard)
    );

    assign halt_taken = bus.i_halt_instr & ~hazard;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            drain_q <= 4'd0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            cnt_q   <= cnt_d;
            done_q  <= (state_d == S_DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.i_dbg_run)
                    state_d = S_RUN;
                else if (bus.i_dbg_step)
                    state_d = S_STEP;
            end
            S_RUN: begin
                if (halt_taken) begin
                    state_d = S_DRAIN;
                    drain_d = DRAIN_LOAD;
                end else if (bus.i_dbg_pause) begin
                    state_d = S_IDLE;
                end
            end
            S_STEP: begin
                if (halt_taken) begin
                    state_d = S_DRAIN;
                    drain_d = DRAIN_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                drain_d = drain_q - 4'd1;
                // <=1 also guards a zero count from locking up
                if (drain_q <= 4'd1) begin
                    state_d = S_DONE;
                    drain_d = 4'd0;
                end
            end
            S_DONE: state_d = S_DONE;
            default: begin
                state_d = S_IDLE;
                drain_d = 4'd0;
            end
        endcase
    end

    always_comb begin
        halt_w           = 1'b1;
        bus.o_pc_write   = 1'b0;
        bus.o_ifid_write = 1'b0;
        bus.o_idex_stall = 1'b0;
        bus.o_ifid_flush = 1'b0;
        unique case (state_q)
            S_RUN, S_STEP: begin
                halt_w = 1'b0;
                if (hazard) begin
                    bus.o_idex_stall = 1'b1;
                end else begin
                    bus.o_pc_write   = 1'b1;
                    bus.o_ifid_write = 1'b1;
                    bus.o_ifid_flush = bus.i_branch_taken;
                end
            end
            S_DRAIN: begin
                halt_w           = 1'b0;
                bus.o_idex_stall = 1'b1;
            end
            default: halt_w = 1'b1;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!halt_w && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    assign bus.o_halt      = halt_w;
    assign bus.o_done      = done_q;
    assign bus.o_state     = state_q;
    assign bus.o_cycle_cnt = cnt_q;

endmodule
